// File: rtl/operand_align.sv
// operand_align
//   Pre-normalisation front end of the binary16 adder. Registers two packed
//   half-precision operands, orders them by magnitude, then right-shifts the
//   smaller mantissa one bit per cycle until both share the larger exponent.
//
//   Optional feature macro: STICKY_EN (adds the sticky output and register).
//
//   Ports
//     clk, rst_n           clock (rising edge), asynchronous active-low reset
//     in_valid / in_ready  operand handshake; A, B sampled in IDLE only
//     A, B [15:0]          {sign, exp[4:0], frac[9:0]}
//     out_valid / out_ready result handshake; outputs held while in DONE
//     exp  [4:0]           larger raw exponent
//     Am   [10:0]          larger-magnitude mantissa {hidden, frac}
//     Bm   [10:0]          smaller-magnitude mantissa, aligned
//     As, Bs               operand signs (never swapped)
//     swap                 1 when |B| > |A|
//     arround              last bit shifted out of Bm
//     sticky               OR of bits shifted out before arround (STICKY_EN)
module operand_align #(
    parameter int MAX_SHIFT = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  exp,
    output logic [10:0] Am,
    output logic [10:0] Bm,
    output logic        As,
    output logic        Bs,
    output logic        swap,
    output logic        arround
`ifdef STICKY_EN
    ,
    output logic        sticky
`endif
);

    localparam int CW = $clog2(MAX_SHIFT + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CMP   = 2'd1;
    localparam logic [1:0] ALIGN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]    state;
    logic [15:0]   ra;
    logic [15:0]   rb;
    logic [CW-1:0] cnt;

    // Compare-stage combinational values, consumed only in CMP.
    logic [4:0]    ea, eb, expl, exps, diff;
    logic [10:0]   ma, mb;
    logic          bgt;
    logic [CW-1:0] nsh;

    always_comb begin
        ea   = ra[14:10];
        eb   = rb[14:10];
        ma   = {|ea, ra[9:0]};
        mb   = {|eb, rb[9:0]};
        // Magnitude order is the unsigned order of {exp, frac}; ties keep A.
        bgt  = rb[14:0] > ra[14:0];
        expl = bgt ? eb : ea;
        exps = bgt ? ea : eb;
        diff = expl - exps;
        nsh  = (32'(diff) >= MAX_SHIFT) ? CW'(MAX_SHIFT) : CW'(diff);
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        As        = ra[15];
        Bs        = rb[15];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ra      <= '0;
            rb      <= '0;
            cnt     <= '0;
            exp     <= '0;
            Am      <= '0;
            Bm      <= '0;
            swap    <= 1'b0;
            arround <= 1'b0;
`ifdef STICKY_EN
            sticky  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ra    <= A;
                        rb    <= B;
                        state <= CMP;
                    end
                end
                CMP: begin
                    swap    <= bgt;
                    exp     <= expl;
                    Am      <= bgt ? mb : ma;
                    Bm      <= bgt ? ma : mb;
                    cnt     <= nsh;
                    arround <= 1'b0;
`ifdef STICKY_EN
                    sticky  <= 1'b0;
`endif
                    state   <= (nsh != '0) ? ALIGN : DONE;
                end
                ALIGN: begin
`ifdef STICKY_EN
                    sticky  <= sticky | arround;
`endif
                    arround <= Bm[0];
                    Bm      <= {1'b0, Bm[10:1]};
                    cnt     <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= DONE;
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
